// File: rtl/ram_copy_engine_if.sv
// Control handshake and dual-port RAM buses for ram_copy_engine.
// master: engine side (drives RAM strobes, status).  slave: controller/RAM side.
interface ram_copy_engine_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] ram_addr_a;
   logic              ram_we_a;
   logic [DATA_W-1:0] ram_q_a;
   logic [ADDR_W-1:0] ram_addr_b;
   logic              ram_we_b;
   logic [DATA_W-1:0] ram_data_b;

   modport master (
      input  start, src_addr, dst_addr, len, ram_q_a,
      output busy, done, ram_addr_a, ram_we_a, ram_addr_b, ram_we_b, ram_data_b
   );

   modport slave (
      output start, src_addr, dst_addr, len, ram_q_a,
      input  busy, done, ram_addr_a, ram_we_a, ram_addr_b, ram_we_b, ram_data_b
   );
endinterface

// File: rtl/ram_copy_engine.sv
// Block-copy engine for the 64x8 synchronous dual-port RAM: reads through
// port A, writes one cycle later through port B, one word per cycle.
// Optional macro RAM_COPY_BACKWARD_EN: copy descending when dst > src so
// forward-overlapping copies behave like memmove.
module ram_copy_engine #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_copy_engine_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_L = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_widx;
   logic [ADDR_W:0]   r_left;
   logic              r_we_b;
   logic [ADDR_W:0]   w_len_sat;
   logic              w_len_zero;
   logic              w_accept;
   logic [ADDR_W-1:0] w_first_idx;
   logic [ADDR_W-1:0] w_next_idx;
   logic [DATA_W-1:0] w_wdata;

   assign w_len_sat  = (bus.len > DEPTH) ? DEPTH : bus.len;
   assign w_len_zero = (bus.len == '0);
   // start is honoured in IDLE and in the done cycle (FIN), never while busy
   assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_FIN));

`ifdef RAM_COPY_BACKWARD_EN
   logic r_desc;
   logic w_desc;

   assign w_desc      = (bus.dst_addr > bus.src_addr);
   assign w_first_idx = w_desc ? (w_len_sat[ADDR_W-1:0] - ONE_A) : '0;
   assign w_next_idx  = r_desc ? (r_idx - ONE_A) : (r_idx + ONE_A);
`else
   assign w_first_idx = '0;
   assign w_next_idx  = r_idx + ONE_A;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and status decode.
   // A zero-length copy spends its single busy cycle in DRAIN with no write
   // pending, so done still arrives len+1 cycles after start.
   always_comb begin
      w_next   = r_state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = w_len_zero ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            bus.busy = 1'b1;
            if (r_left == '0) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            bus.busy = 1'b1;
            w_next   = S_FIN;
         end
         S_FIN: begin
            bus.done = 1'b1;
            if (bus.start) begin
               w_next = w_len_zero ? S_DRAIN : S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Latch copy parameters at start, step the read index, and delay the
   // read index by one cycle to form the matching write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_idx  <= '0;
         r_widx <= '0;
         r_left <= '0;
         r_we_b <= 1'b0;
`ifdef RAM_COPY_BACKWARD_EN
         r_desc <= 1'b0;
`endif
      end else begin
         r_we_b <= (r_state == S_RUN);
         r_widx <= r_idx;
         if (w_accept) begin
            r_src  <= bus.src_addr;
            r_dst  <= bus.dst_addr;
            r_left <= w_len_zero ? '0 : (w_len_sat - ONE_L);
            r_idx  <= w_first_idx;
`ifdef RAM_COPY_BACKWARD_EN
            r_desc <= w_desc;
`endif
         end else if ((r_state == S_RUN) && (r_left != '0)) begin
            r_left <= r_left - ONE_L;
            r_idx  <= w_next_idx;
         end
      end
   end

   assign w_wdata        = r_we_b ? bus.ram_q_a : '0;
   assign bus.ram_we_a   = 1'b0;
   assign bus.ram_addr_a = (r_state == S_RUN) ? (r_src + r_idx) : '0;
   assign bus.ram_we_b   = r_we_b;
   assign bus.ram_addr_b = r_we_b ? (r_dst + r_widx) : '0;
   assign bus.ram_data_b = w_wdata;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 64x8 dual-port RAM
// and a write scoreboard (expected port-B writes queued at start, popped as
// the engine writes).
module tb_ram_copy_engine;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 64;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic          pl_en   = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   wr_t           exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ram_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // RAM model: registered read on A, write on B, old data on collision
   always @(posedge clk) begin
      bus.ram_q_a <= mem[bus.ram_addr_a];
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (pl_en) ref_mem[pl_addr] <= pl_data;
         if (bus.ram_we_b) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", bus.ram_we_b, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", bus.ram_addr_b, e.a);
               check("wr_data", bus.ram_data_b, e.d);
               ref_mem[e.a] <= e.d;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input int a, input logic [DW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a[AW-1:0];
      pl_data = d;
      tick();
      pl_en   = 1'b0;
   endtask

   // Expected write stream: read k lands at E(k+1), write k commits at
   // E(k+2), so read k sees writes 0..k-2 only.
   task automatic build_expected(input int s, input int d, input int l);
      logic [DW-1:0] m   [DEPTH];
      logic [DW-1:0] val [DEPTH];
      int            idx [DEPTH];
      int            n;
      bit            desc;
      wr_t           e;
      n    = (l > int'(DEPTH)) ? int'(DEPTH) : l;
      desc = 1'b0;
`ifdef RAM_COPY_BACKWARD_EN
      desc = (d > s);
`endif
      for (int i = 0; i < int'(DEPTH); i++) m[i] = ref_mem[i];
      for (int k = 0; k < n; k++) idx[k] = desc ? (n - 1 - k) : k;
      for (int k = 0; k < n; k++) begin
         if (k >= 2) m[(d + idx[k-2]) % int'(DEPTH)] = val[k-2];
         val[k] = m[(s + idx[k]) % int'(DEPTH)];
         e.a = AW'((d + idx[k]) % int'(DEPTH));
         e.d = val[k];
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_start(input int s, input int d, input int l);
      bus.src_addr = s[AW-1:0];
      bus.dst_addr = d[AW-1:0];
      bus.len      = l[AW:0];
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic run_copy(input int s, input int d, input int l,
                           output int done_cyc, output int we_cnt, output bit we_contig);
      int first, last;
      build_expected(s, d, l);
      drive_start(s, d, l);
      check("busy_after_start", bus.busy, 1);
      if (l > 0) check("addr_a_first", bus.ram_addr_a, s % int'(DEPTH));
      done_cyc = -1;
      we_cnt   = 0;
      first    = -1;
      last     = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (bus.ram_we_b) begin
            we_cnt++;
            if (first < 0) first = k;
            last = k;
         end
         if (bus.done) begin
            done_cyc = k;
            break;
         end
      end
      we_contig = (we_cnt == 0) || ((first == 1) && (last - first + 1 == we_cnt));
      check("busy_in_done", bus.busy, 0);
      tick();
      check("done_single", bus.done, 0);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_image(input string tag);
      for (int i = 0; i < int'(DEPTH); i++)
         check($sformatf("%s_mem%0d", tag, i), mem[i], ref_mem[i]);
   endtask

   initial begin
      int            dc, wc, ndone;
      bit            contig;
      logic [DW-1:0] old3 [6];

      bus.start    = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.len      = '0;

      // reset state
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_we_a", bus.ram_we_a, 0);
      check("rst_we_b", bus.ram_we_b, 0);
      check("rst_addr_a", bus.ram_addr_a, 0);
      check("rst_addr_b", bus.ram_addr_b, 0);
      check("rst_data_b", bus.ram_data_b, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < int'(DEPTH); i++) poke(i, 8'hC0 ^ DW'(i));
      for (int i = 0; i < 8; i++) poke(i, 8'h10 + DW'(i));
      tick();

      // basic ascending copy
      run_copy(0, 32, 8, dc, wc, contig);
      check("t1_done_cycle", dc, 9);
      check("t1_we_count", wc, 8);
      check("t1_we_contig", contig, 1);
      for (int i = 0; i < 8; i++) check($sformatf("t1_word%0d", 32 + i), mem[32+i], 8'h10 + DW'(i));
      check_image("t1");

      // zero length
      run_copy(7, 50, 0, dc, wc, contig);
      check("t2_done_cycle", dc, 1);
      check("t2_we_count", wc, 0);
      check_image("t2");

      // wrap-around source
      old3[0] = 8'hFC; old3[1] = 8'hFD; old3[2] = 8'hFE;
      old3[3] = 8'hFF; old3[4] = 8'h10; old3[5] = 8'h11;
      run_copy(60, 10, 6, dc, wc, contig);
      check("t3_done_cycle", dc, 7);
      check("t3_we_count", wc, 6);
      for (int i = 0; i < 6; i++) check($sformatf("t3_word%0d", 10 + i), mem[10+i], old3[i]);
      check_image("t3");

      // start while busy is ignored
      build_expected(0, 48, 8);
      drive_start(0, 48, 8);
      ndone = 0;
      dc    = -1;
      for (int k = 1; k <= 30; k++) begin
         if (k == 3) begin
            bus.src_addr = 6'd8;
            bus.dst_addr = 6'd20;
            bus.len      = 7'd4;
            bus.start    = 1'b1;
         end
         if (k == 4) bus.start = 1'b0;
         tick();
         if (bus.done) begin
            ndone++;
            if (dc < 0) dc = k;
         end
      end
      check("t4_done_count", ndone, 1);
      check("t4_done_cycle", dc, 9);
      check("t4_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 8; i++) check($sformatf("t4_word%0d", 48 + i), mem[48+i], 8'h10 + DW'(i));
      for (int i = 0; i < 4; i++) check($sformatf("t4_untouched%0d", 20 + i), mem[20+i], 8'hC0 ^ DW'(20 + i));
      check_image("t4");

      // reset mid-copy
      build_expected(0, 40, 8);
      drive_start(0, 40, 8);
      tick();
      tick();
      tick();
      check("t5_we_b_before", bus.ram_we_b, 1);
      rst_n = 1'b0;
      #1;
      check("t5_we_b", bus.ram_we_b, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_done", bus.done, 0);
      check("t5_addr_a", bus.ram_addr_a, 0);
      check("t5_addr_b", bus.ram_addr_b, 0);
      check("t5_data_b", bus.ram_data_b, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t5_no_done", bus.done, 0);
      end
      rst_n = 1'b1;
      tick();
      check("t5_idle_after", bus.busy, 0);
      check_image("t5_partial");
      run_copy(0, 40, 8, dc, wc, contig);
      check("t5_restart_done", dc, 9);
      check_image("t5");

      // forward-overlapping copy
      for (int i = 0; i < 8; i++) poke(i, 8'hA0 + DW'(i));
      tick();
      run_copy(0, 3, 8, dc, wc, contig);
      check("t6_done_cycle", dc, 9);
`ifdef RAM_COPY_BACKWARD_EN
      for (int i = 0; i < 8; i++) check($sformatf("t6_word%0d", 3 + i), mem[3+i], 8'hA0 + DW'(i));
`endif
      check_image("t6");

      // length saturation
      run_copy(5, 5, 100, dc, wc, contig);
      check("t7_done_cycle", dc, 65);
      check("t7_we_count", wc, 64);
      check("t7_we_contig", contig, 1);
      check_image("t7");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
